// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the M-stage load/store unit: memop codes, FSM
// states, write-buffer entry layout, alignment, byte-enable and load-extension logic.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } memop_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_REQ  = 3'd1,
        S_R_REQ  = 3'd2,
        S_R_WAIT = 3'd3,
        S_R_DONE = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wbuf_entry_t;

    function automatic logic is_load(input logic [3:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        logic half, word;
        half = op == OP_LH || op == OP_LHU || op == OP_SH;
        word = op == OP_LW || op == OP_SW;
        return (half && a[0]) || (word && a != 2'b00);
    endfunction

    // Loads reuse the same lane mask so the bus sees which bytes are consumed.
    function automatic logic [3:0] byteen(input logic [3:0] op, input logic [1:0] a);
        if (op == OP_SB || op == OP_LB || op == OP_LBU) return 4'b0001 << a;
        if (op == OP_SH || op == OP_LH || op == OP_LHU) return 4'b0011 << {a[1], 1'b0};
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        if (op == OP_SB) return {4{d[7:0]}};
        if (op == OP_SH) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic [15:0] h;
        sh = rd >> {a, 3'b000};
        h  = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return {24'h0, sh[7:0]};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_wbuf.sv
// Posted-store FIFO: circular buffer with read/write pointers and an explicit
// occupancy count so full/empty need no extra pointer bit.
module lsu_wbuf
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wbuf_entry_t              din,
    output wbuf_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == FULLC;
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: posts stores into a write buffer, runs the load
// handshake against a variable-latency data bus and generates pipeline stalls.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        M_valid,
    input  logic [31:0]                 M_PC,
    input  logic [3:0]                  M_memop,
    input  logic                        M_fence,
    input  logic [31:0]                 M_ALUResult,
    input  logic [31:0]                 M_Forward2,
    input  logic [4:0]                  M_A3,
    input  logic [31:0]                 M_WD,
    output logic [4:0]                  M_A3_W,
    output logic [31:0]                 M_WD_W,
    output logic [31:0]                 m_inst_addr,
    output logic                        mem_stall,
    output logic                        exc_adel,
    output logic                        exc_ades,
    output logic                        m_data_req,
    output logic                        m_data_we,
    output logic [ADDR_W-1:0]           m_data_addr,
    output logic [31:0]                 m_data_wdata,
    output logic [3:0]                  m_data_byteen,
    input  logic                        m_data_gnt,
    input  logic                        m_data_rvalid,
    input  logic [31:0]                 m_data_rdata,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);
    lsu_state_e  state_q, state_d;
    logic [31:0] load_addr_q, load_addr_d, load_data_q, load_data_d;
    logic [3:0]  memop_q, memop_d;
    logic        mis, ld_ok, st_ok, wb_push, wb_pop, wb_full, wb_empty;
    logic [31:0] bus_addr;
    wbuf_entry_t wb_din, wb_head;

    assign mis      = misaligned(M_memop, M_ALUResult[1:0]);
    assign ld_ok    = M_valid && is_load(M_memop) && !mis;
    assign st_ok    = M_valid && is_store(M_memop) && !mis;
    assign exc_adel = M_valid && is_load(M_memop) && mis;
    assign exc_ades = M_valid && is_store(M_memop) && mis;
    // Admission looks only at start-of-cycle occupancy; a same-cycle pop does not help.
    assign wb_push  = st_ok && !wb_full;

    assign wb_din.addr  = {M_ALUResult[31:2], 2'b00};
    assign wb_din.wdata = store_data(M_memop, M_Forward2);
    assign wb_din.be    = byteen(M_memop, M_ALUResult[1:0]);

    lsu_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   (wb_din),
        .head  (wb_head),
        .full  (wb_full),
        .empty (wb_empty),
        .count (wbuf_count)
    );

    always_comb begin
        state_d       = state_q;
        load_addr_d   = load_addr_q;
        memop_d       = memop_q;
        load_data_d   = load_data_q;
        wb_pop        = 1'b0;
        m_data_req    = 1'b0;
        m_data_we     = 1'b0;
        bus_addr      = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        case (state_q)
            S_IDLE: begin
                // Loads wait for an empty buffer, which removes any need to forward.
                if (ld_ok && wb_empty) begin
                    state_d     = S_R_REQ;
                    load_addr_d = M_ALUResult;
                    memop_d     = M_memop;
                end else if (!wb_empty || wb_push) begin
                    state_d = S_W_REQ;
                end
            end
            S_W_REQ: begin
                m_data_req    = 1'b1;
                m_data_we     = 1'b1;
                bus_addr      = wb_head.addr;
                m_data_wdata  = wb_head.wdata;
                m_data_byteen = wb_head.be;
                if (m_data_gnt) begin
                    wb_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_R_REQ: begin
                m_data_req    = 1'b1;
                bus_addr      = {load_addr_q[31:2], 2'b00};
                m_data_byteen = byteen(memop_q, load_addr_q[1:0]);
                if (m_data_gnt) state_d = S_R_WAIT;
            end
            S_R_WAIT: begin
                if (m_data_rvalid) begin
                    load_data_d = load_ext(memop_q, load_addr_q[1:0], m_data_rdata);
                    state_d     = S_R_DONE;
                end
            end
            S_R_DONE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            load_addr_q <= '0;
            memop_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            memop_q     <= memop_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_stall   = (ld_ok && state_q != S_R_DONE) || (st_ok && wb_full) ||
                         (M_valid && M_fence && (!wb_empty || state_q != S_IDLE));
    assign m_data_addr = bus_addr[ADDR_W-1:0];
    assign M_A3_W      = M_A3;
    assign M_WD_W      = is_load(M_memop) ? load_data_q : M_WD;
    assign m_inst_addr = M_PC;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads with extension, buffer full,
// ordering, misalignment, fence drain and asynchronous reset.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        M_valid, M_fence;
    logic [31:0] M_PC, M_ALUResult, M_Forward2, M_WD;
    logic [3:0]  M_memop;
    logic [4:0]  M_A3, M_A3_W;
    logic [31:0] M_WD_W, m_inst_addr;
    logic        mem_stall, exc_adel, exc_ades;
    logic        m_data_req, m_data_we, m_data_gnt, m_data_rvalid;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic [2:0]  wbuf_count;

    int errors = 0;
    int checks = 0;
    logic        ev_we[$];
    logic [31:0] ev_addr[$];
    logic [31:0] ev_wd[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.WBUF_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .M_valid(M_valid), .M_PC(M_PC), .M_memop(M_memop),
        .M_fence(M_fence), .M_ALUResult(M_ALUResult), .M_Forward2(M_Forward2),
        .M_A3(M_A3), .M_WD(M_WD), .M_A3_W(M_A3_W), .M_WD_W(M_WD_W),
        .m_inst_addr(m_inst_addr), .mem_stall(mem_stall), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .m_data_req(m_data_req), .m_data_we(m_data_we),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_gnt(m_data_gnt),
        .m_data_rvalid(m_data_rvalid), .m_data_rdata(m_data_rdata),
        .wbuf_count(wbuf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and acts as the bus: grants each request after
    // gwait cycles and returns read data the cycle after a read grant.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input int gwait,
                          output int stalls, output logic [31:0] wd);
        int gcnt;
        bit rpend, done;
        stalls = 0; gcnt = 0; rpend = 0; done = 0; wd = 'x;
        M_valid = 1'b1; M_memop = op; M_ALUResult = addr;
        for (int c = 0; c < 60 && !done; c++) begin
            m_data_rvalid = rpend;
            rpend = 0;
            m_data_gnt = 1'b0;
            #1;
            if (m_data_req) begin
                if (gcnt >= gwait) begin
                    m_data_gnt = 1'b1;
                    ev_we.push_back(m_data_we);
                    ev_addr.push_back(m_data_addr);
                    ev_wd.push_back(m_data_wdata);
                    if (!m_data_we) rpend = 1;
                    gcnt = 0;
                end else gcnt++;
            end
            #1;
            if (!mem_stall) begin
                done = 1; wd = M_WD_W;
                M_valid = 1'b0; M_memop = OP_NONE; M_fence = 1'b0;
            end else stalls++;
            step();
        end
        m_data_gnt = 1'b0; m_data_rvalid = 1'b0;
        chk("op_completes", 32'(done), 32'd1);
    endtask

    task automatic clear_ev();
        ev_we.delete(); ev_addr.delete(); ev_wd.delete();
    endtask

    initial begin
        int st;
        logic [31:0] wd;
        reset = 1'b0;
        M_valid = 0; M_fence = 0; M_memop = OP_NONE; M_PC = 32'h0040_0100;
        M_ALUResult = 0; M_Forward2 = 0; M_A3 = 5'd9; M_WD = 32'h55;
        m_data_gnt = 0; m_data_rvalid = 0; m_data_rdata = 0;
        #2;
        chk("rst_req", m_data_req, 0);
        chk("rst_bus", {m_data_we, m_data_byteen, m_data_addr[3:0]}, 0);
        chk("rst_wdata", m_data_wdata, 0);
        chk("rst_count", wbuf_count, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_wdw", M_WD_W, 32'h55);
        chk("pass_a3_pc", {M_A3_W, m_inst_addr}, {5'd9, 32'h0040_0100});
        @(negedge clk) reset = 1'b1;
        step();

        // SB posted without stall, written on the next cycle
        M_valid = 1; M_memop = OP_SB; M_ALUResult = 32'h1003; M_Forward2 = 32'hAB;
        #1;
        chk("sb_stall", mem_stall, 0);
        chk("sb_noreq", m_data_req, 0);
        step();
        M_valid = 0; M_memop = OP_NONE; m_data_gnt = 1;
        #1;
        chk("sb_count", wbuf_count, 1);
        chk("sb_req", {m_data_req, m_data_we}, 2'b11);
        chk("sb_addr", m_data_addr, 32'h1000);
        chk("sb_be", m_data_byteen, 4'b1000);
        chk("sb_wdata", m_data_wdata, 32'hABABABAB);
        step();
        m_data_gnt = 0;
        chk("sb_drained", {wbuf_count, m_data_req}, 0);

        // loads with extension, best case and extra grant latency
        m_data_rdata = 32'h8001_1234;
        clear_ev();
        run_op(OP_LH, 32'h2002, 0, st, wd);
        chk("lh_stalls", st, 3);
        chk("lh_data", wd, 32'hFFFF_8001);
        chk("lh_addr", ev_addr[0], 32'h2000);
        run_op(OP_LHU, 32'h2002, 0, st, wd);
        chk("lhu_stalls", st, 3);
        chk("lhu_data", wd, 32'h0000_8001);
        run_op(OP_LH, 32'h2000, 0, st, wd);
        chk("lh_low", wd, 32'h0000_1234);
        run_op(OP_LB, 32'h2001, 0, st, wd);
        chk("lb_1", wd, 32'h0000_0012);
        run_op(OP_LB, 32'h2003, 0, st, wd);
        chk("lb_3", wd, 32'hFFFF_FF80);
        run_op(OP_LBU, 32'h2003, 0, st, wd);
        chk("lbu_3", wd, 32'h0000_0080);
        run_op(OP_LW, 32'h2000, 2, st, wd);
        chk("lw_slow_stalls", st, 5);
        chk("lw_slow_data", wd, 32'h8001_1234);

        // fill the buffer with gnt low, then one more SW must stall
        for (int i = 0; i < 4; i++) begin
            M_valid = 1; M_memop = OP_SW; M_ALUResult = 32'h100 + 4 * i;
            M_Forward2 = 32'h1000 + i;
            #1;
            chk("fill_stall", mem_stall, 0);
            step();
        end
        M_ALUResult = 32'h200; M_Forward2 = 32'h2000;
        #1;
        chk("full_count", wbuf_count, 4);
        chk("full_stall", mem_stall, 1);
        chk("full_head", m_data_addr, 32'h100);
        step();
        chk("full_stall2", mem_stall, 1);
        m_data_gnt = 1;
        #1;
        chk("full_head_wd", m_data_wdata, 32'h1000);
        step();
        m_data_gnt = 0;
        #1;
        chk("pop_count", wbuf_count, 3);
        chk("pop_unstall", mem_stall, 0);
        step();
        M_valid = 0; M_memop = OP_NONE;
        chk("refill_count", wbuf_count, 4);
        // fence drains the buffer, recording FIFO order
        clear_ev();
        M_fence = 1;
        run_op(OP_NONE, 32'h0, 0, st, wd);
        chk("fence_stalls", st, 7);
        chk("drain_n", ev_addr.size(), 4);
        chk("drain_0", ev_addr[0], 32'h104);
        chk("drain_1", ev_addr[1], 32'h108);
        chk("drain_2", ev_addr[2], 32'h10C);
        chk("drain_3", ev_addr[3], 32'h200);
        chk("drain_3wd", ev_wd[3], 32'h2000);
        chk("drain_empty", wbuf_count, 0);

        // SW then LW to same address: write must precede read
        clear_ev();
        M_valid = 1; M_memop = OP_SW; M_ALUResult = 32'h10; M_Forward2 = 32'h77;
        #1;
        chk("swlw_sw_stall", mem_stall, 0);
        step();
        m_data_rdata = 32'hCAFE_F00D;
        run_op(OP_LW, 32'h10, 0, st, wd);
        chk("swlw_stalls", st, 4);
        chk("swlw_n", ev_we.size(), 2);
        chk("swlw_first", {31'b0, ev_we[0]}, 1);
        chk("swlw_first_a", ev_addr[0], 32'h10);
        chk("swlw_first_wd", ev_wd[0], 32'h77);
        chk("swlw_second", {31'b0, ev_we[1]}, 0);
        chk("swlw_second_a", ev_addr[1], 32'h10);
        chk("swlw_data", wd, 32'hCAFE_F00D);

        // misalignment
        M_valid = 1; M_memop = OP_LW; M_ALUResult = 32'h3001;
        #1;
        chk("adel", {exc_adel, exc_ades}, 2'b10);
        chk("adel_quiet", {m_data_req, mem_stall}, 0);
        M_memop = OP_SH; M_ALUResult = 32'h3003;
        #1;
        chk("ades", {exc_adel, exc_ades}, 2'b01);
        chk("ades_quiet", {m_data_req, mem_stall}, 0);
        step();
        chk("mis_nopush", wbuf_count, 0);
        M_valid = 0; M_memop = OP_NONE;

        // reset while in R_WAIT with two buffered stores
        M_valid = 1; M_memop = OP_LW; M_ALUResult = 32'h40; m_data_gnt = 1;
        step();
        step();
        m_data_gnt = 0;
        M_memop = OP_SW; M_ALUResult = 32'h50; M_Forward2 = 32'h5;
        step();
        step();
        chk("rw_count", wbuf_count, 2);
        chk("rw_noreq", m_data_req, 0);
        reset = 1'b0;
        #1;
        chk("rst_mid_req", m_data_req, 0);
        chk("rst_mid_count", wbuf_count, 0);
        M_valid = 0; M_memop = OP_LW;
        @(negedge clk) reset = 1'b1;
        step();
        m_data_rvalid = 1; m_data_rdata = 32'hDEAD_BEEF;
        step();
        m_data_rvalid = 0;
        chk("late_rvalid", M_WD_W, 0);
        chk("late_idle", {m_data_req, wbuf_count}, 0);

        // reset while a write request is on the bus
        M_valid = 1; M_memop = OP_SW; M_ALUResult = 32'h60; M_Forward2 = 32'h6;
        step();
        M_valid = 0; M_memop = OP_NONE;
        #1;
        chk("wreq_up", m_data_req, 1);
        reset = 1'b0;
        #1;
        chk("wreq_drop", m_data_req, 0);
        chk("wreq_count", wbuf_count, 0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("post_rst_idle", m_data_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
